// File: rtl/rr_pri_arbiter.sv
// Round-robin arbiter for up to 16 requesters: a rotating pointer masks the
// request vector, a lowest-index priority encode picks the winner.
module rr_pri_arbiter #(
  parameter int NREQ     = 16,
  parameter int IDXW     = 4,
  parameter int MAX_HOLD = 0,
  parameter int HCW      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_index,
  output logic            gnt_valid,
  output logic            preempt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HCW-1:0] HOLD_SAT  = {HCW{1'b1}};

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IDXW-1:0] gnt_index_q;
  logic            gnt_valid_q;
  logic            preempt_q;
  logic [IDXW-1:0] ptr_q;
  logic [HCW-1:0]  hold_cnt_q;

  logic [IDXW-1:0] ptr_d;
  logic [HCW-1:0]  hold_cnt_d;

  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] first_masked;
  logic [NREQ-1:0] first_req;
  logic [NREQ-1:0] win_onehot;
  logic [IDXW-1:0] win_index;

  // Requests at or above the pointer get first pick; below it only as fallback.
  assign masked = req & ~((NREQ'(1) << ptr_q) - NREQ'(1));

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign first_masked[gi] = masked[gi];
        assign first_req[gi]    = req[gi];
      end else begin : g_upper
        assign first_masked[gi] = masked[gi] & ~(|masked[gi-1:0]);
        assign first_req[gi]    = req[gi] & ~(|req[gi-1:0]);
      end
    end
  endgenerate

  assign win_onehot = (|masked) ? first_masked : first_req;

  always_comb begin
    win_index = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) win_index = win_index | IDXW'(i);
    end
  end

  logic cur_req;
  logic rel_drop;
  logic rel_timeout;

  assign cur_req     = req[gnt_index_q];
  assign rel_drop    = ~cur_req | ~enable;
  assign rel_timeout = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && cur_req;

  // Pointer arithmetic relies on NREQ == 2**IDXW so index 15 wraps to 0.
  assign ptr_d      = gnt_index_q + IDXW'(1);
  assign hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HCW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_index_q <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          preempt_q <= 1'b0;
          if (enable && (|req)) begin
            state_q     <= GRANT;
            gnt_q       <= win_onehot;
            gnt_index_q <= win_index;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
          end
        end
        GRANT: begin
          if (rel_drop || rel_timeout) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_index_q <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            preempt_q   <= rel_timeout & ~rel_drop;
          end else begin
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          gnt_index_q <= '0;
          gnt_valid_q <= 1'b0;
          preempt_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_index = gnt_index_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_pri_arbiter.sv
// Bench for rr_pri_arbiter: an unlimited-hold and a MAX_HOLD=4 instance share
// stimulus; a behavioural model feeds a per-cycle scoreboard, plus directed checks.
module tb_rr_pri_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] req = 16'h0000;

  logic [15:0] gnt0, gnt4;
  logic [3:0]  idx0, idx4;
  logic        val0, val4, pre0, pre4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_pri_arbiter #(.NREQ(16), .IDXW(4), .MAX_HOLD(0), .HCW(8)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .gnt(gnt0), .gnt_index(idx0), .gnt_valid(val0), .preempt(pre0)
  );

  rr_pri_arbiter #(.NREQ(16), .IDXW(4), .MAX_HOLD(4), .HCW(8)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .gnt(gnt4), .gnt_index(idx4), .gnt_valid(val4), .preempt(pre4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: winner is the first requester found scanning upward from ptr.
  typedef struct {
    logic       busy;
    logic [3:0] idx;
    int         ptr;
    int         hold;
    logic       pre;
  } mdl_t;

  function automatic mdl_t step(input mdl_t s, input logic rst, input logic en,
                                input logic [15:0] r, input int max_hold);
    mdl_t n = s;
    if (rst) begin
      n.busy = 0; n.idx = 0; n.ptr = 0; n.hold = 0; n.pre = 0;
    end else if (!s.busy) begin
      n.pre = 0;
      if (en && r != 16'h0) begin
        for (int k = 15; k >= 0; k--) begin
          if (r[(s.ptr + k) % 16]) n.idx = 4'((s.ptr + k) % 16);
        end
        n.busy = 1;
        n.hold = 0;
      end
    end else begin
      logic drop, tmo;
      drop = !r[s.idx] || !en;
      tmo  = (max_hold != 0) && (s.hold == max_hold - 1) && r[s.idx];
      if (drop || tmo) begin
        n.busy = 0;
        n.ptr  = (int'(s.idx) + 1) % 16;
        n.pre  = tmo && !drop;
      end else begin
        n.pre  = 0;
        n.hold = (s.hold < 255) ? s.hold + 1 : s.hold;
      end
    end
    return n;
  endfunction

  function automatic logic [21:0] pack(input mdl_t m);
    logic [15:0] g;
    g = m.busy ? (16'h0001 << m.idx) : 16'h0000;
    return {m.pre, m.busy, (m.busy ? m.idx : 4'h0), g};
  endfunction

  typedef struct {
    logic [21:0] v0;
    logic [21:0] v4;
  } exp_t;

  mdl_t m0 = '{busy: 1'b0, idx: 4'h0, ptr: 0, hold: 0, pre: 1'b0};
  mdl_t m4 = '{busy: 1'b0, idx: 4'h0, ptr: 0, hold: 0, pre: 1'b0};
  exp_t sb[$];

  always @(posedge clk) begin
    m0 = step(m0, reset, enable, req, 0);
    m4 = step(m4, reset, enable, req, 4);
    sb.push_back('{v0: pack(m0), v4: pack(m4)});
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("sb_hold0", {10'h0, pre0, val0, idx0, gnt0}, {10'h0, e.v0});
      check_eq("sb_hold4", {10'h0, pre4, val4, idx4, gnt4}, {10'h0, e.v4});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    req    = 16'h0000;
    tick();
    reset  = 1'b0;
  endtask

  // Expected {valid, preempt, index} of the MAX_HOLD=4 instance with req=0x0024.
  logic [5:0] pre_tab [15] = '{6'h22, 6'h22, 6'h22, 6'h22, 6'h10,
                               6'h25, 6'h25, 6'h25, 6'h25, 6'h10,
                               6'h22, 6'h22, 6'h22, 6'h22, 6'h10};

  initial begin
    int order[$];
    logic prev_val;

    // Idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_gnt", {16'h0, gnt0}, 32'h0);
      check_eq("idle_valid_index", {27'h0, val0, idx0}, 32'h0);
    end

    // Hold while requested, then hand over to 15 after a bubble
    do_reset();
    req = 16'h8001;
    tick();
    check_eq("hold_first_gnt", {16'h0, gnt0}, 32'h0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("hold_gnt", {16'h0, gnt0}, 32'h0001);
    end
    req = 16'h8000;
    tick();
    check_eq("drop_bubble", {15'h0, val0, gnt0}, 32'h0);
    tick();
    check_eq("next_gnt", {16'h0, gnt0}, 32'h8000);
    check_eq("next_index", {28'h0, idx0}, 32'd15);

    // Fairness: every requester drops its request on its third grant cycle
    do_reset();
    prev_val = 1'b0;
    for (int c = 0; c < 200 && order.size() < 17; c++) begin
      req = (m0.busy && m0.hold == 2) ? (16'hFFFF & ~(16'h0001 << m0.idx)) : 16'hFFFF;
      tick();
      if (val0 && !prev_val) order.push_back(int'(idx0));
      prev_val = val0;
    end
    check_eq("rr_order_len", order.size(), 32'd17);
    for (int i = 0; i < order.size(); i++) begin
      check_eq($sformatf("rr_order[%0d]", i), order[i], i % 16);
    end

    // Preemption by hold limit
    do_reset();
    req = 16'h0024;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq($sformatf("preempt_seq[%0d]", i), {26'h0, val4, pre4, idx4}, {26'h0, pre_tab[i]});
    end

    // Enable removes the grant without a preempt pulse
    do_reset();
    req = 16'h0080;
    tick();
    check_eq("en_grant7", {27'h0, val0, idx0}, 32'h17);
    tick();
    enable = 1'b0;
    tick();
    check_eq("en_off_gnt", {15'h0, pre0, gnt0}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("en_off_idle", {31'h0, val0}, 32'h0);
    end
    enable = 1'b1;
    req    = 16'h0081;
    tick();
    check_eq("en_on_fallback", {27'h0, val0, idx0}, 32'h10);

    // Reset in the middle of a grant
    do_reset();
    req = 16'h0200;
    tick();
    check_eq("mid_grant9", {27'h0, val0, idx0}, 32'h19);
    reset = 1'b1;
    req   = 16'h0201;
    tick();
    check_eq("mid_reset_out", {10'h0, pre0, val0, idx0, gnt0}, 32'h0);
    reset = 1'b0;
    tick();
    check_eq("post_reset_grant", {27'h0, val0, idx0}, 32'h10);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_pri_arbiter.md
Name: rr_pri_arbiter

Overview:
- 16-requester round-robin arbiter built around a lowest-index-first priority encode of the request vector.
- Shares one downstream resource among up to 16 masters.
- Grant is held for as long as the winner keeps its request asserted, with an optional hold-time limit.
- A global enable gates arbitration, in the same way the encoder enable forces a zero output.

Parameters:
- NREQ, 16, number of requesters; fixed at 16 in this revision.
- IDXW, 4, width of the grant index (log2 NREQ).
- MAX_HOLD, 0, maximum consecutive grant cycles per winner; 0 = unlimited.
- HCW, 8, width of the hold counter; MAX_HOLD must be <= 2**HCW.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  arbitration enable; low = no new grants, current grant dropped.
- req  input  16  per-requester request, level-sensitive.
- gnt  output  16  one-hot grant, registered.
- gnt_index  output  4  binary index of the granted requester, registered; 0 when no grant.
- gnt_valid  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse when a grant is removed by MAX_HOLD timeout.

Behaviour:
- Reset: reset sampled high at a clk edge sets the following, regardless of state (reset mid-grant included): state=IDLE, gnt=0, gnt_index=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0.
- State machine: two states, IDLE and GRANT.
- Arbitration, evaluated combinationally in IDLE:
  - masked = req & ~((1<<ptr)-1).
  - Winner = lowest set bit of masked if masked != 0, else lowest set bit of req.
  - Lowest index wins within each set.
- IDLE:
  - If enable=1 and req!=0: next edge sets state=GRANT, gnt=1<<winner, gnt_index=winner, gnt_valid=1, hold_cnt=0.
  - Otherwise stay in IDLE with outputs 0.
  - Latency: request sampled in IDLE -> grant visible 1 cycle later.
- GRANT, release conditions (any one, evaluated on the current cycle):
  - (a) req[gnt_index]=0.
  - (b) enable=0.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and req[gnt_index]=1.
- On release, next edge:
  - state=IDLE; gnt, gnt_index, gnt_valid cleared.
  - ptr=(gnt_index+1) mod 16; index 15 wraps to 0.
  - preempt=1 only if (c) caused the release and (a)/(b) did not; otherwise preempt=0.
- GRANT with no release condition: hold_cnt increments, saturating at 2**HCW-1; grant outputs unchanged.
- Changes on other req bits during GRANT are ignored.
- Bubble: one mandatory IDLE cycle between consecutive grants. A new grant appears 2 cycles after the releasing cycle.
- The same requester may win again after release if no other request is pending.
- preempt is high for exactly one cycle, coincident with the first cycle gnt_valid=0.
- Invariants:
  - gnt is zero or one-hot.
  - gnt == (gnt_valid ? 1<<gnt_index : 0).
- enable=0 in IDLE: ptr holds its value; requests stay pending.

Test Plan:
- Reset then req=16'h0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_index=0 throughout.
- req=16'h8001 held, MAX_HOLD=0, ptr=0 -> grant to 0 one cycle later, held indefinitely. Drop req[0] -> gnt=0 next cycle, then gnt=16'h8000, gnt_index=15 one cycle after that.
- Round-robin fairness and wrap: all 16 requests asserted, each requester drops its request 3 cycles after its grant -> grant order 0,1,…,15,0 with a 1-cycle bubble between grants; ptr wraps 15->0.
- Preemption: MAX_HOLD=4, req=16'h0024 held -> gnt_index=2 for exactly 4 cycles, preempt pulses once, next grant gnt_index=5 for 4 cycles, then back to 2.
- Enable: grant active on index 7, enable driven 0 -> gnt=0 next cycle, preempt=0, no further grants while enable=0. enable=1 with req=16'h0081 -> next grant index 0 (ptr=8, masked=0, fallback to lowest overall).
- Reset mid-grant: gnt_index=9 active, reset pulsed 1 cycle -> all outputs 0 next edge, ptr=0. With req=16'h0201 held, first post-reset grant is index 0.
